// File: rtl/easyaxi_run_ctrl_if.sv
// easyaxi_run_ctrl_if: control/status bundle between the run controller and its environment.
// Latency: none, plain wires.
// Backpressure: none; levels and one-cycle pulses only, no handshake.
//
// Signals:
//   start       one-cycle pulse, launches a run from IDLE, DONE or TOUT
//   abort       one-cycle pulse, drops all enables and returns to IDLE
//   auto_start  static strap, IDLE launches without a start pulse
//   ch_done     per-channel completion level
//   ch_en       per-channel enable to the EasyAXI masters
//   busy        high while settling, ramping or running
//   done        sticky completion flag
//   timeout     sticky watchdog-expiry flag
//   run_cycles  captured run length (zero unless cycle capture is built in)
//
// Modports: master = environment side (drives requests, observes status),
//           slave  = run controller side.
interface easyaxi_run_ctrl_if #(
  parameter int NUM_CH = 2,
  parameter int CNT_W  = 16
);
  logic              start;
  logic              abort;
  logic              auto_start;
  logic [NUM_CH-1:0] ch_done;
  logic [NUM_CH-1:0] ch_en;
  logic              busy;
  logic              done;
  logic              timeout;
  logic [CNT_W-1:0]  run_cycles;

  modport master (
    output start, abort, auto_start, ch_done,
    input  ch_en, busy, done, timeout, run_cycles
  );

  modport slave (
    input  start, abort, auto_start, ch_done,
    output ch_en, busy, done, timeout, run_cycles
  );
endinterface

// File: rtl/easyaxi_run_ctrl.sv
// easyaxi_run_ctrl: reset/enable sequencer with completion/timeout watchdog for EasyAXI.
// Latency: first ch_en SETTLE_CYC+1 cycles after launch; status flags one cycle after the deciding sample.
// Backpressure: none; start while busy is dropped, abort always wins over start.
//
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset, forces IDLE and clears every output
//   bus  easyaxi_run_ctrl_if.slave (start, abort, auto_start, ch_done in;
//        ch_en, busy, done, timeout, run_cycles out)
//
// Optional feature: define EASYAXI_RUN_CTRL_CYCLE_CAPTURE_EN to build the
// run-length capture register; otherwise run_cycles is tied to zero.
//
// Timing reference (launch edge L, first-enable edge E = L+SETTLE_CYC+1):
//   ch_en[i] rises at E + i*STAGGER_CYC, watchdog reads 0 at E and k at E+k,
//   so a starved run reaches TOUT exactly TIMEOUT_CYC edges after E.
module easyaxi_run_ctrl #(
  parameter int NUM_CH      = 2,
  parameter int SETTLE_CYC  = 5,
  parameter int STAGGER_CYC = 1,
  parameter int TIMEOUT_CYC = 1000,
  parameter int CNT_W       = 16
) (
  input logic               clk,
  input logic               rst,
  easyaxi_run_ctrl_if.slave bus
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [CNT_W-1:0]  SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0]  STAGGER_LAST = CNT_W'(STAGGER_CYC - 1);
  localparam logic [CNT_W-1:0]  TOUT_LAST    = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST     = IDX_W'(NUM_CH - 1);
  localparam logic [NUM_CH-1:0] EN_ONE       = NUM_CH'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_RAMP,
    S_RUN,
    S_DONE,
    S_TOUT
  } state_e;

  // With no settle delay the launch edge goes straight to RAMP so the first
  // enable still lands SETTLE_CYC+1 = 1 cycle after launch.
  localparam state_e LAUNCH_ST = (SETTLE_CYC == 0) ? S_RAMP : S_SETTLE;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  wdog_q;
  logic [IDX_W-1:0]  idx_q;
  logic [NUM_CH-1:0] ch_en_q;
  logic              busy_q;
  logic              done_q;
  logic              tout_q;

  logic [CNT_W-1:0]  wdog_d;
  logic              wdog_last;
  logic              run_complete;
  logic              first_en;
  logic              idle_launch;
  logic              term_launch;

`ifdef EASYAXI_RUN_CTRL_CYCLE_CAPTURE_EN
  logic [CNT_W-1:0]  run_cycles_q;
`endif

  // Saturating watchdog increment: a budget near the counter limit must not
  // wrap back and re-arm the timeout compare.
  assign wdog_d       = (wdog_q == {CNT_W{1'b1}}) ? wdog_q : wdog_q + CNT_W'(1);
  assign wdog_last    = (wdog_q == TOUT_LAST);
  // Only enabled channels are looked at; in RUN every channel is enabled.
  assign run_complete = ((bus.ch_done & ch_en_q) == ch_en_q);
  // No enable raised yet means this RAMP cycle is the first-enable cycle.
  assign first_en     = ~|ch_en_q;
  // Abort in the same cycle suppresses any launch.
  assign idle_launch  = (bus.start | bus.auto_start) & ~bus.abort;
  assign term_launch  = bus.start & ~bus.abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      wdog_q       <= '0;
      idx_q        <= '0;
      ch_en_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      tout_q       <= 1'b0;
`ifdef EASYAXI_RUN_CTRL_CYCLE_CAPTURE_EN
      run_cycles_q <= '0;
`endif
    end else if (bus.abort && (state_q != S_IDLE)) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      ch_en_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      tout_q       <= 1'b0;
`ifdef EASYAXI_RUN_CTRL_CYCLE_CAPTURE_EN
      run_cycles_q <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (idle_launch) begin
            state_q <= LAUNCH_ST;
            busy_q  <= 1'b1;
            wdog_q  <= '0;
            idx_q   <= '0;
`ifdef EASYAXI_RUN_CTRL_CYCLE_CAPTURE_EN
            run_cycles_q <= '0;
`endif
          end
        end

        S_SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            state_q <= S_RAMP;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        S_RAMP: begin
          if (first_en) begin
            // Watchdog starts together with the first enable.
            wdog_q <= '0;
            cnt_q  <= '0;
            if ((STAGGER_CYC == 0) || (NUM_CH == 1)) begin
              ch_en_q <= '1;
              state_q <= S_RUN;
            end else begin
              ch_en_q <= EN_ONE;
              idx_q   <= IDX_W'(1);
            end
          end else begin
            wdog_q <= wdog_d;
            if (wdog_last) begin
              // Completion is only judged in RUN, so expiry here is a timeout.
              state_q <= S_TOUT;
              ch_en_q <= '0;
              busy_q  <= 1'b0;
              tout_q  <= 1'b1;
`ifdef EASYAXI_RUN_CTRL_CYCLE_CAPTURE_EN
              run_cycles_q <= wdog_q + CNT_W'(1);
`endif
            end else if (cnt_q == STAGGER_LAST) begin
              ch_en_q <= ch_en_q | (EN_ONE << idx_q);
              cnt_q   <= '0;
              if (idx_q == IDX_LAST) begin
                state_q <= S_RUN;
              end else begin
                idx_q <= idx_q + IDX_W'(1);
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end

        S_RUN: begin
          wdog_q <= wdog_d;
          // Completion is tested first so it wins over a coincident expiry.
          if (run_complete) begin
            state_q <= S_DONE;
            ch_en_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
`ifdef EASYAXI_RUN_CTRL_CYCLE_CAPTURE_EN
            run_cycles_q <= wdog_q + CNT_W'(1);
`endif
          end else if (wdog_last) begin
            state_q <= S_TOUT;
            ch_en_q <= '0;
            busy_q  <= 1'b0;
            tout_q  <= 1'b1;
`ifdef EASYAXI_RUN_CTRL_CYCLE_CAPTURE_EN
            run_cycles_q <= wdog_q + CNT_W'(1);
`endif
          end
        end

        S_DONE, S_TOUT: begin
          // auto_start deliberately has no effect here; only an explicit start relaunches.
          if (term_launch) begin
            state_q <= LAUNCH_ST;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            tout_q  <= 1'b0;
            cnt_q   <= '0;
            wdog_q  <= '0;
            idx_q   <= '0;
`ifdef EASYAXI_RUN_CTRL_CYCLE_CAPTURE_EN
            run_cycles_q <= '0;
`endif
          end
        end

        default: begin
          state_q <= S_IDLE;
          ch_en_q <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          tout_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ch_en   = ch_en_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.timeout = tout_q;

`ifdef EASYAXI_RUN_CTRL_CYCLE_CAPTURE_EN
  assign bus.run_cycles = run_cycles_q;
`else
  assign bus.run_cycles = '0;
`endif

endmodule

// File: tb/tb_easyaxi_run_ctrl.sv
// tb_easyaxi_run_ctrl: scoreboard bench for easyaxi_run_ctrl.
// Reference model tracks run phase and launch time; outputs derived arithmetically.
// Monitor compares one expected snapshot per cycle on the falling clock edge.
module tb_easyaxi_run_ctrl;
  localparam int NUM_CH  = 4;
  localparam int SETTLE  = 5;
  localparam int STAGGER = 2;
  localparam int TIMEOUT = 40;
  localparam int CNT_W   = 16;

  localparam int P_IDLE = 0;
  localparam int P_ACT  = 1;
  localparam int P_DONE = 2;
  localparam int P_TOUT = 3;

  typedef struct packed {
    logic [NUM_CH-1:0] en;
    logic              busy;
    logic              done;
    logic              tout;
    logic [CNT_W-1:0]  rc;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  easyaxi_run_ctrl_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) bus ();

  easyaxi_run_ctrl #(
    .NUM_CH     (NUM_CH),
    .SETTLE_CYC (SETTLE),
    .STAGGER_CYC(STAGGER),
    .TIMEOUT_CYC(TIMEOUT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  obs_t sb_q[$];
  int   n_chk  = 0;
  int   n_err  = 0;
  bit   mon_en = 1'b0;

  // Reference model state: edge counter, phase, launch edge, captured length.
  int t_now = 0;
  int ph    = P_IDLE;
  int l_edge = 0;
  int cap   = 0;

  function automatic obs_t sample();
    obs_t o;
    o.en   = bus.ch_en;
    o.busy = bus.busy;
    o.done = bus.done;
    o.tout = bus.timeout;
    o.rc   = bus.run_cycles;
    return o;
  endfunction

  function automatic void check(string name, obs_t got, obs_t exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d got en=%b busy=%b done=%b tout=%b rc=%0d expected en=%b busy=%b done=%b tout=%b rc=%0d",
               name, t_now, got.en, got.busy, got.done, got.tout, got.rc,
               exp.en, exp.busy, exp.done, exp.tout, exp.rc);
    end
  endfunction

  // Advance the model by one clock edge using the inputs that edge sampled,
  // then queue the outputs expected after that edge.
  task automatic model_edge();
    int   e;
    int   a_edge;
    obs_t x;
    t_now++;
    e      = l_edge + SETTLE + 1;
    a_edge = e + (NUM_CH - 1) * STAGGER;
    if (rst) begin
      ph  = P_IDLE;
      cap = 0;
    end else begin
      case (ph)
        P_IDLE: if ((bus.start || bus.auto_start) && !bus.abort) begin
          ph = P_ACT; l_edge = t_now; cap = 0;
        end
        P_ACT: begin
          if (bus.abort) begin
            ph = P_IDLE; cap = 0;
          end else if (t_now > a_edge && bus.ch_done == {NUM_CH{1'b1}}) begin
            ph = P_DONE; cap = t_now - e;
          end else if (t_now == e + TIMEOUT) begin
            ph = P_TOUT; cap = t_now - e;
          end
        end
        default: begin
          if (bus.abort) begin
            ph = P_IDLE; cap = 0;
          end else if (bus.start) begin
            ph = P_ACT; l_edge = t_now; cap = 0;
          end
        end
      endcase
    end
    e    = l_edge + SETTLE + 1;
    x    = '0;
    x.busy = (ph == P_ACT);
    x.done = (ph == P_DONE);
    x.tout = (ph == P_TOUT);
    if (ph == P_ACT) begin
      for (int i = 0; i < NUM_CH; i++)
        if (t_now >= e + i * STAGGER) x.en[i] = 1'b1;
    end
`ifdef EASYAXI_RUN_CTRL_CYCLE_CAPTURE_EN
    x.rc = CNT_W'(cap);
`else
    x.rc = '0;
`endif
    sb_q.push_back(x);
  endtask

  task automatic step(input bit s, input bit a, input logic [NUM_CH-1:0] cd);
    bus.start   = s;
    bus.abort   = a;
    bus.ch_done = cd;
    @(posedge clk);
    #1;
    model_edge();
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL sb_empty t=%0d got no expectation, expected one queued", t_now);
      end else begin
        check("scoreboard", sample(), sb_q.pop_front());
      end
    end
  end

  initial begin
    obs_t zero;
    int   mode;
    bit   s;
    bit   a;
    logic [NUM_CH-1:0] cd;
    zero           = '0;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.auto_start = 1'b1;
    bus.ch_done    = '0;

    // Reset state, then release with auto_start strapped high.
    #1;
    check("reset_state", sample(), zero);
    mon_en = 1'b1;
    repeat (3) step(0, 0, '0);
    rst = 1'b0;

    // Auto launch, ramp, then completion well inside the budget.
    while (t_now < l_edge + SETTLE + 1 + 20) step(0, 0, '0);
    step(0, 0, '1);
    repeat (4) step(0, 0, '0);

    // Relaunch from DONE and starve it into a timeout.
    step(1, 0, '0);
    while (t_now < l_edge + SETTLE + 1 + TIMEOUT + 2) step(0, 0, '0);

    // Relaunch from TOUT; completion coincides with the last budget cycle.
    step(1, 0, '0);
    while (t_now < l_edge + SETTLE + TIMEOUT) step(0, 0, '0);
    step(0, 0, '1);
    repeat (3) step(0, 0, '0);

    // Abort from DONE, then abort mid-ramp, then abort together with start.
    bus.auto_start = 1'b0;
    step(0, 1, '0);
    step(1, 0, '0);
    while (t_now < l_edge + SETTLE + 1 + STAGGER) step(0, 0, '0);
    step(0, 1, '0);
    step(1, 1, '0);
    repeat (3) step(0, 0, '0);

    // Asynchronous reset between edges while running, then auto relaunch.
    bus.auto_start = 1'b1;
    step(0, 0, '0);
    while (t_now < l_edge + SETTLE + 1 + (NUM_CH - 1) * STAGGER + 3) step(0, 0, '0);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", sample(), zero);
    sb_q.delete();
    sb_q.push_back(zero);
    repeat (2) step(0, 0, '0);
    rst = 1'b0;
    repeat (20) step(0, 0, '0);

    // Randomised traffic: segments of fast completion, starvation and bursts.
    mode = 0;
    for (int c = 0; c < 2500; c++) begin
      if (c % 200 == 0) mode = int'($urandom_range(0, 2));
      if ($urandom_range(0, 199) == 0) bus.auto_start = ~bus.auto_start;
      s = ($urandom_range(0, 15) == 0);
      a = ($urandom_range(0, 79) == 0);
      case (mode)
        0:       cd = NUM_CH'($urandom);
        1:       cd = '0;
        default: cd = ($urandom_range(0, 7) == 0) ? {NUM_CH{1'b1}} : NUM_CH'($urandom_range(0, 7));
      endcase
      step(s, a, cd);
    end
    step(0, 0, '0);

    @(negedge clk);
    #1;
    n_chk++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL sb_drain got %0d entries left, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
